sm_rf_arbiter: RTL and testbench

- Shares the single register-file write port between the core writeback path and a debug/loader requester.
- Also provides debug read access through a dedicated register-file read port.
- Sits between the core datapath, the register file and the debug interface.
- Core writeback normally has priority. A starvation counter forces a debug write through after a bounded wait by stalling the core for one cycle.

---
 rtl/sm_rf_arbiter.sv | 100 ++++++++++
 tb/tb_sm_rf_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_rf_arbiter.sv
// Register-file write-port arbiter: core writeback vs debug/loader.
// Debug writes win after a bounded starvation wait; debug reads use a side port.
module sm_rf_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_we,
  input  logic [AW-1:0] core_wa,
  input  logic [DW-1:0] core_wd,
  output logic          core_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_a,
  input  logic [DW-1:0] dbg_wd,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rd,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          cap_we;
  logic [AW-1:0] cap_a;
  logic [DW-1:0] cap_wd;
  logic [DW-1:0] rd_q;
  logic          grant;

  assign grant = (state == SERVE) && cap_we &&
                 (!core_we || (cnt == LIM));

  assign dbg_ack = (state == ACK);
  assign dbg_rd  = rd_q;
  assign rf_ra   = cap_a;

  // Write port mux: core passes through unless debug is granted
  always_comb begin
    rf_we      = core_we;
    rf_wa      = core_wa;
    rf_wd      = core_wd;
    core_stall = 1'b0;
    if (grant) begin
      rf_we      = |cap_a;
      rf_wa      = cap_a;
      rf_wd      = cap_wd;
      core_stall = core_we;
    end
  end

  // Transaction FSM, capture registers and starvation counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      cap_we <= 1'b0;
      cap_a  <= '0;
      cap_wd <= '0;
      rd_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dbg_req) begin
            cap_we <= dbg_we;
            cap_a  <= dbg_a;
            cap_wd <= dbg_wd;
            state  <= SERVE;
          end
        end
        SERVE: begin
          if (!cap_we) begin
            rd_q  <= rf_rd;
            state <= ACK;
          end else if (grant) begin
            cnt   <= '0;
            state <= ACK;
          end else if (cnt != LIM) begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_rf_arbiter.sv
// Self-checking bench for sm_rf_arbiter.
// Directed table, corner sequences, then random traffic vs a transaction model.
module tb_sm_rf_arbiter;

  localparam int LIMIT = 8;

  logic        clk;
  logic        rst;
  logic        core_we;
  logic [4:0]  core_wa;
  logic [31:0] core_wd;
  logic        core_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_a;
  logic [31:0] dbg_wd;
  logic        dbg_ack;
  logic [31:0] dbg_rd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  rf_ra;
  logic [31:0] rf_rd;

  logic [31:0] mem [32];
  assign rf_rd = mem[rf_ra];

  sm_rf_arbiter #(
    .STARVE_LIMIT(LIMIT), .DW(32), .AW(5)
  ) dut (
    .clk(clk), .rst(rst),
    .core_we(core_we), .core_wa(core_wa),
    .core_wd(core_wd), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_a(dbg_a), .dbg_wd(dbg_wd),
    .dbg_ack(dbg_ack), .dbg_rd(dbg_rd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_ra(rf_ra), .rf_rd(rf_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // transaction-level reference model
  logic        m_pv;
  logic        m_pwe;
  logic [4:0]  m_pa;
  logic [31:0] m_pwd;
  int          m_blk;
  logic        m_ackn;
  logic [4:0]  m_lasta;
  logic [31:0] m_rd;

  typedef struct {
    logic        rst;
    logic        cwe;
    logic [4:0]  cwa;
    logic [31:0] cwd;
    logic        req;
    logic        dwe;
    logic [4:0]  da;
    logic [31:0] dwd;
    logic        e_stall;
    logic        e_ack;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [4:0]  e_ra;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(
    logic req, logic dwe, logic [4:0] da, logic [31:0] dwd,
    logic es, logic ea, logic ew, logic [4:0] ewa,
    logic [31:0] ewd, logic [4:0] era, logic [31:0] erd);
    vec_t v;
    v.rst = 1'b1; v.cwe = 1'b0; v.cwa = '0; v.cwd = '0;
    v.req = req; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.e_stall = es; v.e_ack = ea; v.e_we = ew;
    v.e_wa = ewa; v.e_wd = ewd; v.e_ra = era; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pv = 0; m_pwe = 0; m_pa = '0; m_pwd = '0;
    m_blk = 0; m_ackn = 0; m_lasta = '0; m_rd = '0;
  endtask

  task automatic model_cycle();
    logic        g;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_st;
    g = m_pv && m_pwe && (!core_we || m_blk == LIMIT);
    e_we = core_we; e_wa = core_wa; e_wd = core_wd;
    e_st = 1'b0;
    if (g) begin
      e_we = (m_pa != 0); e_wa = m_pa; e_wd = m_pwd;
      e_st = core_we;
    end
    chk("m_rf_we", rf_we, e_we);
    chk("m_rf_wa", rf_wa, e_wa);
    chk("m_rf_wd", rf_wd, e_wd);
    chk("m_stall", core_stall, e_st);
    chk("m_ack", dbg_ack, m_ackn);
    chk("m_rf_ra", rf_ra, m_lasta);
    chk("m_dbg_rd", dbg_rd, m_rd);
    if (!rst) begin
      model_reset();
    end else if (m_ackn) begin
      m_ackn = 0;
    end else if (m_pv) begin
      if (!m_pwe) begin
        m_rd = mem[m_pa]; m_pv = 0; m_ackn = 1;
      end else if (g) begin
        m_blk = 0; m_pv = 0; m_ackn = 1;
      end else if (m_blk < LIMIT) begin
        m_blk++;
      end
    end else if (dbg_req) begin
      m_pv = 1; m_pwe = dbg_we; m_pa = dbg_a;
      m_pwd = dbg_wd; m_lasta = dbg_a;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic finish_cyc();
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    model_cycle();
    wv = rf_we; wa = rf_wa; wd = rf_wd;
    @(posedge clk);
    #1;
    if (wv === 1'b1) mem[wa] = wd;
    @(negedge clk);
  endtask

  logic hold;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[5] = 32'hDEADBEEF;
    mem[6] = 32'h66666666;
    rst = 0; core_we = 0; core_wa = '0; core_wd = '0;
    dbg_req = 0; dbg_we = 0; dbg_a = '0; dbg_wd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    settle();
    chk("rst_ack", dbg_ack, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_ra", rf_ra, 5'd0);
    chk("rst_rd", dbg_rd, 32'h0);

    // directed table: read x5, write x7, write x0
    tbl[0] = mk(1,0,5,0, 0,0,0,0,0, 0,0);
    tbl[1] = mk(1,0,5,0, 0,0,0,0,0, 5,0);
    tbl[2] = mk(0,0,5,0, 0,1,0,0,0, 5,32'hDEADBEEF);
    tbl[3] = mk(1,1,7,32'h12345678,
                0,0,0,0,0, 5,32'hDEADBEEF);
    tbl[4] = mk(1,1,7,32'h12345678,
                0,0,1,7,32'h12345678, 7,32'hDEADBEEF);
    tbl[5] = mk(0,1,7,32'h12345678,
                0,1,0,0,0, 7,32'hDEADBEEF);
    tbl[6] = mk(1,1,0,32'hFFFFFFFF,
                0,0,0,0,0, 7,32'hDEADBEEF);
    tbl[7] = mk(1,1,0,32'hFFFFFFFF,
                0,0,0,0,32'hFFFFFFFF, 0,32'hDEADBEEF);
    tbl[8] = mk(0,1,0,32'hFFFFFFFF,
                0,1,0,0,0, 0,32'hDEADBEEF);
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; core_we = tbl[i].cwe;
      core_wa = tbl[i].cwa; core_wd = tbl[i].cwd;
      dbg_req = tbl[i].req; dbg_we = tbl[i].dwe;
      dbg_a = tbl[i].da; dbg_wd = tbl[i].dwd;
      settle();
      chk($sformatf("t%0d_stall", i), core_stall, tbl[i].e_stall);
      chk($sformatf("t%0d_ack", i), dbg_ack, tbl[i].e_ack);
      chk($sformatf("t%0d_we", i), rf_we, tbl[i].e_we);
      chk($sformatf("t%0d_wa", i), rf_wa, tbl[i].e_wa);
      chk($sformatf("t%0d_wd", i), rf_wd, tbl[i].e_wd);
      chk($sformatf("t%0d_ra", i), rf_ra, tbl[i].e_ra);
      chk($sformatf("t%0d_rd", i), dbg_rd, tbl[i].e_rd);
      finish_cyc();
    end

    // starvation: core writes x3 every cycle
    core_we = 1; core_wa = 5'd3; core_wd = 32'h33333333;
    dbg_req = 1; dbg_we = 1; dbg_a = 5'd9;
    dbg_wd = 32'hA5A5A5A5;
    settle();
    finish_cyc();
    for (int i = 1; i <= LIMIT; i++) begin
      settle();
      chk("stv_blk_wa", rf_wa, 5'd3);
      chk("stv_blk_stall", core_stall, 1'b0);
      finish_cyc();
    end
    settle();
    chk("stv_gnt_wa", rf_wa, 5'd9);
    chk("stv_gnt_we", rf_we, 1'b1);
    chk("stv_gnt_wd", rf_wd, 32'hA5A5A5A5);
    chk("stv_gnt_stall", core_stall, 1'b1);
    chk("stv_gnt_ack", dbg_ack, 1'b0);
    finish_cyc();
    dbg_req = 0;
    settle();
    chk("stv_ack", dbg_ack, 1'b1);
    chk("stv_ack_stall", core_stall, 1'b0);
    chk("stv_ack_wa", rf_wa, 5'd3);
    finish_cyc();

    // reset during a blocked write
    core_wa = 5'd2; core_wd = 32'h22222222;
    dbg_req = 1; dbg_we = 1; dbg_a = 5'd4;
    dbg_wd = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      settle();
      finish_cyc();
    end
    rst = 0;
    settle();
    finish_cyc();
    rst = 1; core_we = 0; dbg_req = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rmo_ack", dbg_ack, 1'b0);
      chk("rmo_we", rf_we, 1'b0);
      chk("rmo_stall", core_stall, 1'b0);
      chk("rmo_ra", rf_ra, 5'd0);
      chk("rmo_rd", dbg_rd, 32'h0);
      finish_cyc();
    end

    // back-to-back reads, request held across the ack
    dbg_req = 1; dbg_we = 0; dbg_a = 5'd5;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) dbg_a = 5'd6;
      if (c == 5) dbg_req = 0;
      settle();
      chk($sformatf("b2b_ack%0d", c), dbg_ack,
          (c == 2 || c == 5));
      if (c == 2) chk("b2b_rd1", dbg_rd, 32'hDEADBEEF);
      if (c == 3) chk("b2b_ra1", rf_ra, 5'd5);
      if (c == 4) chk("b2b_ra2", rf_ra, 5'd6);
      if (c == 5) chk("b2b_rd2", dbg_rd, 32'h66666666);
      finish_cyc();
    end

    // random traffic against the model
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) != 0);
      core_we = ($urandom_range(0, 3) != 0);
      core_wa = 5'($urandom);
      core_wd = $urandom;
      if (!hold && $urandom_range(0, 2) == 0) begin
        hold = 1;
        dbg_we = 1'($urandom_range(0, 1));
        dbg_a = 5'($urandom);
        dbg_wd = $urandom;
      end else if (hold && $urandom_range(0, 3) == 0) begin
        dbg_we = 1'($urandom_range(0, 1));
        dbg_a = 5'($urandom);
        dbg_wd = $urandom;
      end
      dbg_req = hold;
      settle();
      if (m_ackn || !rst) hold = 0;
      finish_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
